bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter that shares the single CPU-side port of the memory-mapped MMU between the instruction-fetch master (M0) and the data-access master (M1). It latches the winning request, drives it onto the MMU port until the bus signals ready or a timeout expires, then returns read data and a one-cycle ready pulse to the requester. It sits between the core's fetch/LSU stages and the MMU, upstream of all slave decoding.

## Interface
- `TO_WIDTH`, default 8: timeout counter width; a transaction aborts after 2^TO_WIDTH−1 BUSY cycles without ready.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `mN_req`  in  1  request from master N (N = 0, 1); held high until `mN_ready`.
- `mN_wen`  in  1  write enable.
- `mN_mode`  in  3  access size/sign mode, passed through unchanged.
- `mN_addr`  in  `XLEN`  byte address.
- `mN_wdata`  in  `XLEN`  write data.
- `mN_rdata`  out  `XLEN`  read data; valid while `mN_ready`.
- `mN_ready`  out  1  one-cycle completion pulse.
- `mN_err`  out  1  timeout flag; valid while `mN_ready`.
- `mmu_wen`  out  1  to MMU `mem_wen`.
- `mmu_mode`  out  3  to MMU `mem_mode`.
- `mmu_addr`  out  `XLEN`  to MMU `mem_addr`.
- `mmu_wdata`  out  `XLEN`  to MMU `mem_dat_i`.
- `mmu_rdata`  in  `XLEN`  from MMU `mem_dat_o`.
- `mmu_ready`  in  1  from MMU `bus_ready_o`.
- `busy`  out  1  high in BUSY or RESP.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if any `mN_req` is high, select a winner, latch its wen/mode/addr/wdata and the owner index, clear the timeout counter, and go to BUSY. Otherwise stay in IDLE.
- Selection without the macro: M1 beats M0.
- BUSY: drive the latched fields onto `mmu_*`.
  - If `mmu_ready` is high: latch `mmu_rdata`, set err=0, go to RESP.
  - Else if the counter equals all-ones: latch rdata=0, set err=1, go to RESP.
  - Else: increment the counter.
- RESP: pulse the owner's `mN_ready` with the latched rdata and err, then return to IDLE. The non-owner's ready, rdata and err stay 0.
- Outside BUSY: `mmu_wen`=0; `mmu_addr`, `mmu_mode` and `mmu_wdata` hold their last latched values. This prevents spurious writes, because the MMU request line is always asserted.
- Request inputs are ignored outside IDLE. Changes to a master's fields after latch have no effect.
- In IDLE, `mN_req` high means a new transaction. A master may keep req high across RESP to issue back-to-back accesses.

## Timing
- Reset: state=IDLE; all `mN_ready`, `mN_err`, `mN_rdata` = 0; `mmu_wen`=0; `mmu_addr`/`mmu_mode`/`mmu_wdata` = 0; `busy`=0; counter=0; round-robin pointer=M0.
- Request seen in IDLE at cycle t: `mmu_*` driven from cycle t+1.
- `mmu_ready` seen at cycle t+k: `mN_ready` high at cycle t+k+1; IDLE at t+k+2.
- Minimum latency from req to ready is 2 cycles (k=1). Maximum is 2^TO_WIDTH+1 cycles.
- Maximum throughput is one transaction per 3 cycles.
- `mmu_ready` outside BUSY is ignored.
- `rst` mid-transaction: abort with no ready pulse; state returns to reset values the next cycle.
- Timeout and `mmu_ready` in the same cycle: ready wins, err=0.

## Configuration
- `BUS_ARB_RR_EN` defined: round-robin on contention.
  - A 1-bit pointer records the last owner; when both request, the master that was not last granted wins.
  - The pointer updates on every grant, including uncontended grants.
  - With reset pointer=M0, M1 wins the first contention.
- `BUS_ARB_RR_EN` undefined: fixed priority M1 > M0; no pointer register exists.

## Structure
- Shared package `bus_arb_pkg`:
  - `arb_state_t` enum {IDLE, BUSY, RESP}.
  - Master index type `arb_owner_t` (1 bit).
  - Localparams `ARB_M_FETCH`=0 and `ARB_M_DATA`=1.
- `XLEN` comes from the common include.
- One sub-module, `bus_arb_timer`: a TO_WIDTH-bit counter with clear, enable and an all-ones `expired` output.

## Test plan
- M0 read of 0x0000_0010 alone; MMU returns 0xDEADBEEF with ready one cycle after drive → `m0_ready` pulse at t+2 with rdata=0xDEADBEEF, err=0; `mmu_wen`=0 throughout.
- Both request in the same cycle, M1 writing 0xA5A5_0000 to 0x8000_0004 → M1 granted first; `mmu_wen`=1 only in BUSY; M0 served after M1's RESP. With `BUS_ARB_RR_EN`, a second simultaneous pair grants M0 first.
- MMU never readies, TO_WIDTH=4 → after 15 BUSY cycles the requester sees ready with err=1 and rdata=0.
- M0 keeps req high across 4 back-to-back reads → exactly one ready per 3 cycles, with correct per-transaction data.
- `rst` asserted in BUSY while `mmu_ready` is high → no ready pulse; the next cycle shows IDLE with all outputs 0.
- M0 changes addr from 0xC000_0000 to 0x0000_0000 mid-BUSY → `mmu_addr` stays 0xC000_0000.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types for the two-master MMU bus arbiter.
// XLEN falls back to 32 when the common include has not defined it.
`ifndef XLEN
`define XLEN 32
`endif

package bus_arb_pkg;

    localparam int unsigned XLEN   = `XLEN;
    localparam int unsigned MODE_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    typedef logic arb_owner_t;

    localparam arb_owner_t ARB_M_FETCH = 1'b0;
    localparam arb_owner_t ARB_M_DATA  = 1'b1;

endpackage

// File: rtl/bus_arb_timer.sv
// Transaction timeout counter: clears on grant, counts stalled BUSY cycles,
// flags expiry when every bit is set.
module bus_arb_timer #(
    parameter int unsigned TO_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [TO_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TO_WIDTH'(1);
        end
    end

    assign expired = &cnt;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter in front of the MMU CPU port (M0 fetch, M1 data).
// Define BUS_ARB_RR_EN for round-robin on contention; default is fixed M1 > M0.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned TO_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_wen,
    input  logic [2:0]        m0_mode,
    input  logic [XLEN-1:0]   m0_addr,
    input  logic [XLEN-1:0]   m0_wdata,
    output logic [XLEN-1:0]   m0_rdata,
    output logic              m0_ready,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_wen,
    input  logic [2:0]        m1_mode,
    input  logic [XLEN-1:0]   m1_addr,
    input  logic [XLEN-1:0]   m1_wdata,
    output logic [XLEN-1:0]   m1_rdata,
    output logic              m1_ready,
    output logic              m1_err,

    output logic              mmu_wen,
    output logic [2:0]        mmu_mode,
    output logic [XLEN-1:0]   mmu_addr,
    output logic [XLEN-1:0]   mmu_wdata,
    input  logic [XLEN-1:0]   mmu_rdata,
    input  logic              mmu_ready,

    output logic              busy
);

    arb_state_t             state;
    arb_owner_t             owner;
    arb_owner_t             grant_c;
    logic                   any_req_c;
    logic                   start_c;
    logic                   done_c;
    logic                   expired;
    logic                   sel_wen_c;
    logic [MODE_W-1:0]      sel_mode_c;
    logic [XLEN-1:0]        sel_addr_c;
    logic [XLEN-1:0]        sel_wdata_c;
    logic [XLEN-1:0]        rsp_rdata_c;
    logic                   rsp_err_c;

    assign any_req_c = m0_req | m1_req;
    assign start_c   = (state == IDLE) && any_req_c;
    assign done_c    = (state == BUSY) && (mmu_ready || expired);

`ifdef BUS_ARB_RR_EN
    arb_owner_t last_owner;

    // Pointer follows every grant so contention alternates.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= ARB_M_FETCH;
        end else if (start_c) begin
            last_owner <= grant_c;
        end
    end

    always_comb begin
        grant_c = ARB_M_FETCH;
        if (m0_req && m1_req) begin
            grant_c = (last_owner == ARB_M_DATA) ? ARB_M_FETCH : ARB_M_DATA;
        end else if (m1_req) begin
            grant_c = ARB_M_DATA;
        end
    end
`else
    always_comb begin
        grant_c = ARB_M_FETCH;
        if (m1_req) begin
            grant_c = ARB_M_DATA;
        end
    end
`endif

    always_comb begin
        sel_wen_c   = m0_wen;
        sel_mode_c  = m0_mode;
        sel_addr_c  = m0_addr;
        sel_wdata_c = m0_wdata;
        if (grant_c == ARB_M_DATA) begin
            sel_wen_c   = m1_wen;
            sel_mode_c  = m1_mode;
            sel_addr_c  = m1_addr;
            sel_wdata_c = m1_wdata;
        end
    end

    // A ready in the expiry cycle still completes cleanly.
    assign rsp_rdata_c = mmu_ready ? mmu_rdata : '0;
    assign rsp_err_c   = ~mmu_ready;

    bus_arb_timer #(
        .TO_WIDTH (TO_WIDTH)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_c),
        .en      ((state == BUSY) && !mmu_ready && !expired),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= ARB_M_FETCH;
            busy      <= 1'b0;
            mmu_wen   <= 1'b0;
            mmu_mode  <= '0;
            mmu_addr  <= '0;
            mmu_wdata <= '0;
            m0_ready  <= 1'b0;
            m0_rdata  <= '0;
            m0_err    <= 1'b0;
            m1_ready  <= 1'b0;
            m1_rdata  <= '0;
            m1_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_c) begin
                        state     <= BUSY;
                        busy      <= 1'b1;
                        owner     <= grant_c;
                        mmu_wen   <= sel_wen_c;
                        mmu_mode  <= sel_mode_c;
                        mmu_addr  <= sel_addr_c;
                        mmu_wdata <= sel_wdata_c;
                    end
                end
                BUSY: begin
                    if (done_c) begin
                        state   <= RESP;
                        mmu_wen <= 1'b0;
                        if (owner == ARB_M_DATA) begin
                            m1_ready <= 1'b1;
                            m1_rdata <= rsp_rdata_c;
                            m1_err   <= rsp_err_c;
                        end else begin
                            m0_ready <= 1'b1;
                            m0_rdata <= rsp_rdata_c;
                            m0_err   <= rsp_err_c;
                        end
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    m0_ready <= 1'b0;
                    m0_rdata <= '0;
                    m0_err   <= 1'b0;
                    m1_ready <= 1'b0;
                    m1_rdata <= '0;
                    m1_err   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expected completions are queued at stimulus
// time and popped on each ready pulse; a small MMU model answers in BUSY.
module tb_bus_arbiter;
    import bus_arb_pkg::*;

    localparam int unsigned TO_W = 4;
    localparam int unsigned XL   = XLEN;

    typedef struct {
        logic          wen;
        logic [2:0]    mode;
        logic [XL-1:0] addr;
        logic [XL-1:0] wdata;
    } req_t;

    typedef struct {
        logic          own;
        logic          wen;
        logic [2:0]    mode;
        logic [XL-1:0] addr;
        logic [XL-1:0] wdata;
        logic [XL-1:0] rdata;
        logic          err;
        int            bcyc;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 1'b0, m0_wen = 1'b0;
    logic [2:0]    m0_mode = '0;
    logic [XL-1:0] m0_addr = '0, m0_wdata = '0;
    logic [XL-1:0] m0_rdata;
    logic          m0_ready, m0_err;
    logic          m1_req = 1'b0, m1_wen = 1'b0;
    logic [2:0]    m1_mode = '0;
    logic [XL-1:0] m1_addr = '0, m1_wdata = '0;
    logic [XL-1:0] m1_rdata;
    logic          m1_ready, m1_err;
    logic          mmu_wen;
    logic [2:0]    mmu_mode;
    logic [XL-1:0] mmu_addr, mmu_wdata;
    logic [XL-1:0] mmu_rdata = '0;
    logic          mmu_ready = 1'b0;
    logic          busy;

    int   n_cmp = 0;
    int   n_mis = 0;
    int   mmu_lat = 1;
    int   bcnt = 0;
    int   cyc = 0;
    int   prev_cyc = 0;
    logic have_prev = 1'b0;
    logic b2b = 1'b0;
    logic glitch = 1'b0;
    logic last_grant = 1'b0;

    txn_t exp_q[$];
    req_t pend0[$];
    req_t pend1[$];

    bus_arbiter #(.TO_WIDTH(TO_W)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_mode(m0_mode), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_mode(m1_mode), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
        .mmu_wen(mmu_wen), .mmu_mode(mmu_mode), .mmu_addr(mmu_addr), .mmu_wdata(mmu_wdata),
        .mmu_rdata(mmu_rdata), .mmu_ready(mmu_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [XL-1:0] rd_fn(input logic [XL-1:0] a);
        return (a == XL'(32'h0000_0010)) ? XL'(32'hDEAD_BEEF) : (a ^ XL'(32'h3C3C_A5A5));
    endfunction

    function automatic logic first_of_pair();
`ifdef BUS_ARB_RR_EN
        return ~last_grant;
`else
        return 1'b1;
`endif
    endfunction

    task automatic push_req(input logic m, input logic w, input logic [2:0] md,
                            input logic [XL-1:0] a, input logic [XL-1:0] d);
        req_t r;
        r.wen = w; r.mode = md; r.addr = a; r.wdata = d;
        if (m) pend1.push_back(r);
        else   pend0.push_back(r);
    endtask

    // Expected entries go in grant order; timeout when the MMU model never answers.
    task automatic push_exp(input logic m, input logic w, input logic [2:0] md,
                            input logic [XL-1:0] a, input logic [XL-1:0] d);
        txn_t t;
        logic to;
        to = (mmu_lat == 0);
        t.own = m; t.wen = w; t.mode = md; t.addr = a; t.wdata = d;
        t.err   = to;
        t.rdata = to ? '0 : rd_fn(a);
        t.bcyc  = to ? (1 << TO_W) : mmu_lat;
        exp_q.push_back(t);
        last_grant = m;
    endtask

    task automatic single(input logic m, input logic w, input logic [2:0] md,
                          input logic [XL-1:0] a, input logic [XL-1:0] d);
        push_req(m, w, md, a, d);
        push_exp(m, w, md, a, d);
    endtask

    task automatic pair(input logic [XL-1:0] a1, input logic [XL-1:0] d1, input logic [XL-1:0] a0);
        logic f;
        f = first_of_pair();
        push_req(1'b1, 1'b1, 3'b010, a1, d1);
        push_req(1'b0, 1'b0, 3'b100, a0, '0);
        if (f) begin
            push_exp(1'b1, 1'b1, 3'b010, a1, d1);
            push_exp(1'b0, 1'b0, 3'b100, a0, '0);
        end else begin
            push_exp(1'b0, 1'b0, 3'b100, a0, '0);
            push_exp(1'b1, 1'b1, 3'b010, a1, d1);
        end
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pend0.size() != 0 || pend1.size() != 0 || busy) && n < max) begin
            @(posedge clk);
            n++;
        end
        #2;
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
    endtask

    // Master drivers, MMU model and scoreboard checker, all on the falling edge.
    always @(negedge clk) begin : mon
        txn_t t;
        cyc++;
        if (!b2b) have_prev = 1'b0;
        if (rst) begin
            chk("ready_during_reset", {m1_ready, m0_ready}, 64'd0);
            exp_q.delete(); pend0.delete(); pend1.delete();
            m0_req = 1'b0; m1_req = 1'b0; mmu_ready = 1'b0; bcnt = 0;
        end else begin
            if (m0_ready || m1_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", {m1_ready, m0_ready}, 64'd0);
                end else begin
                    t = exp_q.pop_front();
                    chk("ready_owner", {m1_ready, m0_ready}, t.own ? 64'd2 : 64'd1);
                    chk("rdata", t.own ? m1_rdata : m0_rdata, t.rdata);
                    chk("err", t.own ? m1_err : m0_err, t.err);
                    chk("other_rdata", t.own ? m0_rdata : m1_rdata, 64'd0);
                    chk("other_err", t.own ? m0_err : m1_err, 64'd0);
                    chk("busy_cycles", 64'(bcnt), 64'(t.bcyc));
                    if (b2b && have_prev) chk("b2b_spacing", 64'(cyc - prev_cyc), 64'd3);
                    prev_cyc = cyc;
                    have_prev = 1'b1;
                end
                if (m0_ready && m0_req) begin
                    if (pend0.size() != 0) pend0.delete(0);
                    m0_req = 1'b0;
                end
                if (m1_ready && m1_req) begin
                    if (pend1.size() != 0) pend1.delete(0);
                    m1_req = 1'b0;
                end
            end

            if (busy && !m0_ready && !m1_ready) begin
                bcnt++;
                if (exp_q.size() == 0) begin
                    chk("busy_without_request", 64'd1, 64'd0);
                end else begin
                    chk("mmu_addr", mmu_addr, exp_q[0].addr);
                    chk("mmu_wen", mmu_wen, exp_q[0].wen);
                    chk("mmu_mode", mmu_mode, exp_q[0].mode);
                    chk("mmu_wdata", mmu_wdata, exp_q[0].wdata);
                end
                mmu_ready = (bcnt == mmu_lat);
                mmu_rdata = mmu_ready ? rd_fn(mmu_addr) : XL'($urandom);
            end else begin
                chk("mmu_wen_outside_busy", mmu_wen, 64'd0);
                bcnt = 0;
                mmu_ready = 1'($urandom_range(0, 1));
                mmu_rdata = XL'($urandom);
            end

            if (!m0_req && pend0.size() != 0) begin
                m0_req = 1'b1; m0_wen = pend0[0].wen; m0_mode = pend0[0].mode;
                m0_addr = pend0[0].addr; m0_wdata = pend0[0].wdata;
            end
            if (!m1_req && pend1.size() != 0) begin
                m1_req = 1'b1; m1_wen = pend1[0].wen; m1_mode = pend1[0].mode;
                m1_addr = pend1[0].addr; m1_wdata = pend1[0].wdata;
            end
            if (glitch && busy && m0_req && !m0_ready) m0_addr = '0;
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 64'd0);
        chk("reset_m0_ready", m0_ready, 64'd0);
        chk("reset_m1_ready", m1_ready, 64'd0);
        chk("reset_m0_rdata", m0_rdata, 64'd0);
        chk("reset_m1_err", m1_err, 64'd0);
        chk("reset_mmu_wen", mmu_wen, 64'd0);
        chk("reset_mmu_addr", mmu_addr, 64'd0);
        #1;
        rst = 1'b0;
        last_grant = 1'b0;

        mmu_lat = 1;
        single(1'b0, 1'b0, 3'b010, XL'(32'h0000_0010), '0);
        drain(20);

        mmu_lat = 2;
        pair(XL'(32'h8000_0004), XL'(32'hA5A5_0000), XL'(32'h0000_0020));
        drain(40);
        single(1'b1, 1'b0, 3'b001, XL'(32'h0000_0030), '0);
        drain(20);
        pair(XL'(32'h8000_0008), XL'(32'h1234_5678), XL'(32'h0000_0024));
        drain(40);

        mmu_lat = 0;
        single(1'b1, 1'b0, 3'b010, XL'(32'h0000_0100), '0);
        drain(60);

        mmu_lat = 1;
        b2b = 1'b1;
        for (int i = 0; i < 4; i++) single(1'b0, 1'b0, 3'b010, XL'(32'h200 + 4 * i), '0);
        drain(40);
        b2b = 1'b0;

        mmu_lat = 6;
        glitch = 1'b1;
        single(1'b0, 1'b0, 3'b010, XL'(32'hC000_0000), '0);
        drain(30);
        glitch = 1'b0;

        mmu_lat = 1;
        single(1'b0, 1'b1, 3'b001, XL'(32'h0000_0044), XL'(32'h0BAD_F00D));
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(busy && mmu_ready && !m0_ready) && n < 20);
        chk("rst_setup_busy_ready", {busy, mmu_ready}, 64'd3);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_busy", busy, 64'd0);
        chk("rst_m0_ready", m0_ready, 64'd0);
        chk("rst_m0_rdata", m0_rdata, 64'd0);
        chk("rst_m0_err", m0_err, 64'd0);
        chk("rst_mmu_wen", mmu_wen, 64'd0);
        chk("rst_mmu_addr", mmu_addr, 64'd0);
        chk("rst_mmu_mode", mmu_mode, 64'd0);
        chk("rst_mmu_wdata", mmu_wdata, 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        last_grant = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        mmu_lat = 3;
        single(1'b1, 1'b1, 3'b010, XL'(32'h8000_0010), XL'(32'hCAFE_0001));
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
